ecc_mod_alu: RTL and testbench
==============================

Name: ecc_mod_alu

Overview:
- Parametrised modular arithmetic unit for the ECC datapath; the next generation of the fixed 256-bit core ALU.
- Supports six modes: add, sub, double, multiply, square and nop.
- Multiplication is done in-block by interleaved (MSB-first shift-add) modular reduction; no external multiplier is needed.
- Uses valid/ready handshakes on both command and result sides with a returned tag, so the point-arithmetic sequencer can pipeline commands and apply backpressure.

Parameters:
- WIDTH, 256: operand, modulus and result width in bits; must be ≥ 4.
- TAG_W, 4: width of the command tag echoed with the result.
- CNT_W, $clog2(WIDTH): width of the multiply bit counter (derived).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  command valid
- o_ready  out  1  command accepted when i_valid && o_ready at a rising edge
- i_op  in  3  opcode: 000 NOP, 001 ADD, 010 SUB, 011 MUL, 100 SQR, 101 DBL; others illegal
- i_tag  in  TAG_W  command tag
- i_a  in  WIDTH  operand A, must be < i_p
- i_b  in  WIDTH  operand B, must be < i_p (ignored by SQR, DBL, NOP)
- i_p  in  WIDTH  modulus, must be > 2
- o_valid  out  1  result valid
- i_ready  in  1  result consumed when o_valid && i_ready at a rising edge
- o_result  out  WIDTH  result, always < p for legal ops
- o_tag  out  TAG_W  tag of the command that produced o_result
- o_err  out  1  high with o_valid when the opcode was illegal
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert use): state IDLE; o_valid=0, o_result=0, o_tag=0, o_err=0, o_busy=0; internal operand, accumulator and counter registers = 0.
- o_ready = (state==IDLE). There is no input buffering: one command is in flight at a time.
- Acceptance latches a, b, p, op and tag. Later changes on the inputs have no effect until the next acceptance.
- States:
  - IDLE:
    - Accept to ARITH for ADD, SUB, DBL, NOP or an illegal op.
    - Accept to MUL for MUL or SQR; counter is loaded to WIDTH-1 and accumulator R cleared to 0.
  - ARITH:
    - One cycle. Result register is written, then go to DONE.
    - ADD: s = a+b computed in WIDTH+1 bits; result = s≥p ? s−p : s.
    - SUB: result = a≥b ? a−b : a−b+p, computed in WIDTH+1 bits and truncated.
    - DBL: same as ADD with b=a.
    - NOP: result = a.
    - Illegal op: result = 0 and o_err is set.
  - MUL: one iteration per cycle, operand bit k = counter, MSB first.
    - d = 2R; d = d≥p ? d−p : d.
    - If bit k of b (or of a for SQR) is 1: t = d+a; t = t≥p ? t−p : t. Otherwise t = d.
    - R ← t.
    - After the iteration with counter==0: result ← t, go to DONE. Otherwise decrement the counter.
  - DONE:
    - o_valid=1; o_result, o_tag and o_err are held stable.
    - On i_ready, go to IDLE and clear o_valid and o_err. o_result and o_tag keep their last values.
- Latency is measured from the acceptance edge to the first cycle o_valid=1:
  - ADD, SUB, DBL, NOP, illegal: 1 edge (o_valid is seen in the 2nd cycle after acceptance).
  - MUL, SQR: WIDTH edges.
- Throughput with i_ready tied high:
  - ADD class: one command per 3 cycles (IDLE→ARITH→DONE).
  - MUL class: one command per WIDTH+2 cycles.
- Backpressure: while i_ready=0 in DONE, the block stays in DONE indefinitely and o_ready stays 0.
- A command presented during the DONE cycle in which i_ready=1 is not accepted. It is accepted in the following IDLE cycle.
- All intermediate sums use WIDTH+1 bits, so there is no overflow when p is close to 2^WIDTH.
- Operands ≥ p or p ≤ 2: result is undefined, but the block must still return to IDLE via the normal handshake (no hang).
- Async reset mid-operation (ARITH, MUL or DONE) aborts the command. No o_valid is produced for it, and all outputs take their reset values.

Decomposition:
- Package ecc_alu_pkg holds:
  - the opcode enum: OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_SQR, OP_DBL;
  - the state enum: IDLE, ARITH, MUL, DONE.
- Sub-module mod_add_reduce (parametrised WIDTH) is combinational: computes (x+y) mod p given x, y < p.
  - Used for ADD and DBL, and instantiated twice in the MUL iteration (for the doubling and the addition).
- SUB stays inline in ecc_mod_alu.

Test Plan:
- WIDTH=8, p=13, ADD a=10 b=7 tag=3 → o_valid in the 2nd cycle after acceptance, o_result=4, o_tag=3, o_err=0.
- WIDTH=8, p=13:
  - SUB a=3 b=5 → o_result=11.
  - DBL a=8 → o_result=3.
  - NOP a=9 → o_result=9.
- WIDTH=8, p=13:
  - MUL a=7 b=9 → o_valid exactly 8 edges after acceptance, o_result=11, o_busy=1 throughout.
  - SQR a=12 → o_result=1.
- WIDTH=256, p = 2^256−2^32−977 (secp256k1):
  - ADD a=p−1 b=1 → result 0.
  - MUL a=p−1 b=p−1 → result 1.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid → o_result, o_tag and o_valid are stable, and o_ready stays 0. A command driven during that time is accepted only after the handshake.
- Illegal op 111 → o_err=1 and o_result=0 with o_valid. Async reset asserted mid-MUL → o_valid=0 and o_busy=0 immediately; the next ADD after release gives the correct result.

Source files
------------

// File: rtl/ecc_alu_pkg.sv
// Shared opcode and state encodings for the ECC modular arithmetic unit.
package ecc_alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_MUL = 3'b011,
    OP_SQR = 3'b100,
    OP_DBL = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARITH = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic is_mul_class(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_SQR);
  endfunction

endpackage

// File: rtl/mod_add_reduce.sv
// Combinational (x + y) mod p for x, y < p; the carry bit of the sum takes part in the compare.
module mod_add_reduce #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] corr_s;

  // Subtracting p modulo 2^WIDTH gives the same low bits as the WIDTH+1-bit difference.
  always_comb begin
    sum_s = {1'b0, x} + {1'b0, y};
    if (sum_s >= {1'b0, p}) begin
      corr_s = p;
    end else begin
      corr_s = '0;
    end
    s = sum_s[WIDTH-1:0] - corr_s;
  end

endmodule

// File: rtl/ecc_mod_alu.sv
// Modular add/sub/double/multiply/square unit with valid/ready command and result handshakes.
module ecc_mod_alu
  import ecc_alu_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int TAG_W = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_p,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_err,
  output logic             o_busy
);

  state_e           state_r, state_nx_s;
  logic [WIDTH-1:0] a_r, a_nx_s, b_r, b_nx_s, p_r, p_nx_s;
  logic [WIDTH-1:0] acc_r, acc_nx_s, result_r, result_nx_s;
  logic [2:0]       op_r, op_nx_s;
  logic [TAG_W-1:0] tag_r, tag_nx_s, tag_out_r, tag_out_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic             valid_r, valid_nx_s, err_r, err_nx_s;

  logic [WIDTH-1:0] add0_x_s, add0_y_s, add0_sum_s, add1_sum_s;
  logic [WIDTH-1:0] mul_t_s, sub_s, arith_s;
  logic             mul_bit_s, arith_err_s;

  // Adder 0 is the ADD/DBL adder in ARITH and the doubling step in MUL.
  always_comb begin
    if (state_r == MUL) begin
      add0_x_s = acc_r;
      add0_y_s = acc_r;
    end else begin
      add0_x_s = a_r;
      add0_y_s = (op_r == OP_DBL) ? a_r : b_r;
    end
  end

  mod_add_reduce #(.WIDTH(WIDTH)) u_add_dbl (
    .x(add0_x_s), .y(add0_y_s), .p(p_r), .s(add0_sum_s)
  );

  mod_add_reduce #(.WIDTH(WIDTH)) u_add_acc (
    .x(add0_sum_s), .y(a_r), .p(p_r), .s(add1_sum_s)
  );

  // One MSB-first shift-add step, and the single-cycle ARITH result.
  always_comb begin
    mul_bit_s = (op_r == OP_SQR) ? a_r[cnt_r] : b_r[cnt_r];
    mul_t_s   = mul_bit_s ? add1_sum_s : add0_sum_s;
    if (a_r >= b_r) begin
      sub_s = a_r - b_r;
    end else begin
      sub_s = a_r - b_r + p_r;
    end
    arith_err_s = 1'b0;
    case (op_r)
      OP_ADD, OP_DBL: arith_s = add0_sum_s;
      OP_SUB:         arith_s = sub_s;
      OP_NOP:         arith_s = a_r;
      default: begin
        arith_s     = '0;
        arith_err_s = 1'b1;
      end
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_nx_s   = state_r;
    a_nx_s       = a_r;
    b_nx_s       = b_r;
    p_nx_s       = p_r;
    op_nx_s      = op_r;
    tag_nx_s     = tag_r;
    acc_nx_s     = acc_r;
    cnt_nx_s     = cnt_r;
    result_nx_s  = result_r;
    tag_out_nx_s = tag_out_r;
    valid_nx_s   = valid_r;
    err_nx_s     = err_r;
    case (state_r)
      IDLE: begin
        if (i_valid) begin
          a_nx_s   = i_a;
          b_nx_s   = i_b;
          p_nx_s   = i_p;
          op_nx_s  = i_op;
          tag_nx_s = i_tag;
          if (is_mul_class(i_op)) begin
            cnt_nx_s   = CNT_W'(WIDTH - 1);
            acc_nx_s   = '0;
            state_nx_s = MUL;
          end else begin
            state_nx_s = ARITH;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      ARITH: begin
        result_nx_s  = arith_s;
        err_nx_s     = arith_err_s;
        tag_out_nx_s = tag_r;
        valid_nx_s   = 1'b1;
        state_nx_s   = DONE;
      end
      MUL: begin
        acc_nx_s = mul_t_s;
        if (cnt_r == '0) begin
          result_nx_s  = mul_t_s;
          err_nx_s     = 1'b0;
          tag_out_nx_s = tag_r;
          valid_nx_s   = 1'b1;
          state_nx_s   = DONE;
        end else begin
          cnt_nx_s = cnt_r - CNT_W'(1);
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_nx_s = 1'b0;
          err_nx_s   = 1'b0;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      p_r       <= '0;
      op_r      <= 3'b000;
      tag_r     <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
      result_r  <= '0;
      tag_out_r <= '0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      a_r       <= a_nx_s;
      b_r       <= b_nx_s;
      p_r       <= p_nx_s;
      op_r      <= op_nx_s;
      tag_r     <= tag_nx_s;
      acc_r     <= acc_nx_s;
      cnt_r     <= cnt_nx_s;
      result_r  <= result_nx_s;
      tag_out_r <= tag_out_nx_s;
      valid_r   <= valid_nx_s;
      err_r     <= err_nx_s;
    end
  end

  assign o_ready  = (state_r == IDLE);
  assign o_busy   = (state_r != IDLE);
  assign o_valid  = valid_r;
  assign o_result = result_r;
  assign o_tag    = tag_out_r;
  assign o_err    = err_r;

endmodule

// File: tb/tb_ecc_mod_alu.sv
// Scoreboard bench: an 8-bit instance (p=13) and a 256-bit instance (secp256k1 prime).
module tb_ecc_mod_alu;
  import ecc_alu_pkg::*;

  typedef struct {
    logic [255:0] res;
    logic [3:0]   tag;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  localparam logic [255:0] P256 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic         clk = 1'b0;
  logic [1:0]   rst_n_v = 2'b11;
  logic [1:0]   vld = 2'b00;
  logic [1:0]   rdy_in = 2'b11;
  logic [2:0]   op_v = 3'b000;
  logic [3:0]   tag_v = 4'd0;
  logic [255:0] a_v = '0, b_v = '0, p_v = '0;
  wire  [1:0]   ordy, ov, oerr, obusy;
  wire  [7:0]   res8;
  wire  [255:0] res256;
  wire  [3:0]   otag [2];
  logic [255:0] ores [2];

  int   cyc = 0, tests = 0, fails = 0;
  exp_t q0[$], q1[$];
  logic [1:0] seen = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ores[0] = {248'd0, res8};
  assign ores[1] = res256;

  ecc_mod_alu #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n_v[0]), .i_valid(vld[0]), .o_ready(ordy[0]),
    .i_op(op_v), .i_tag(tag_v), .i_a(a_v[7:0]), .i_b(b_v[7:0]), .i_p(p_v[7:0]),
    .o_valid(ov[0]), .i_ready(rdy_in[0]), .o_result(res8), .o_tag(otag[0]),
    .o_err(oerr[0]), .o_busy(obusy[0])
  );

  ecc_mod_alu #(.WIDTH(256), .TAG_W(4)) u_dut256 (
    .i_clk(clk), .i_rst_n(rst_n_v[1]), .i_valid(vld[1]), .o_ready(ordy[1]),
    .i_op(op_v), .i_tag(tag_v), .i_a(a_v), .i_b(b_v), .i_p(p_v),
    .o_valid(ov[1]), .i_ready(rdy_in[1]), .o_result(res256), .o_tag(otag[1]),
    .o_err(oerr[1]), .o_busy(obusy[1])
  );

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  // Drives a command and waits (bounded) until it is accepted; optionally scoreboards it.
  task automatic issue(input int w, input logic [2:0] op, input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] p, input logic [3:0] tag, input logic [255:0] er,
                       input logic ee, input int lat, input bit push);
    int   n;
    exp_t e;
    @(negedge clk);
    op_v = op; a_v = a; b_v = b; p_v = p; tag_v = tag;
    vld[w] = 1'b1;
    n = 0;
    while (!ordy[w] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!ordy[w]) begin
      tests++; fails++;
      $display("FAIL accept_timeout: dut%0d o_ready stayed 0, expected 1", w);
      vld[w] = 1'b0;
    end else begin
      e.res = er; e.tag = tag; e.err = ee; e.lat = lat; e.acc = cyc;
      if (push) begin
        if (w == 0) q0.push_back(e);
        else q1.push_back(e);
      end
      @(posedge clk);
      #1 vld[w] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while (((w == 0) ? q0.size() : q1.size()) != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (((w == 0) ? q0.size() : q1.size()) != 0) begin
      tests++; fails++;
      $display("FAIL result_timeout: dut%0d still has %0d results pending, expected 0", w,
               (w == 0) ? q0.size() : q1.size());
    end
    @(negedge clk);
  endtask

  // Monitor: pop and compare on the first cycle of each o_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    for (int w = 0; w < 2; w++) begin
      if (ov[w] && !seen[w]) begin
        seen[w] <= 1'b1;
        if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
          tests++; fails++;
          $display("FAIL unexpected_valid: dut%0d result %0h with no command pending", w, ores[w]);
        end else begin
          if (w == 0) e = q0.pop_front();
          else e = q1.pop_front();
          check("result", ores[w], e.res);
          check("tag", 256'(otag[w]), 256'(e.tag));
          check("err", 256'(oerr[w]), 256'(e.err));
          check("latency", 256'(cyc - e.acc - 1), 256'(e.lat));
        end
      end else if (!ov[w]) begin
        seen[w] <= 1'b0;
      end
    end
  end

  initial begin
    logic busy_ok;
    int   n;
    #2 rst_n_v = 2'b00;
    #1;
    check("rst_valid", 256'(ov[0]), 256'd0);
    check("rst_result", ores[0], 256'd0);
    check("rst_tag", 256'(otag[0]), 256'd0);
    check("rst_err", 256'(oerr[0]), 256'd0);
    check("rst_busy", 256'(obusy[0]), 256'd0);
    check("rst_ready", 256'(ordy[0]), 256'd1);
    @(negedge clk);
    rst_n_v = 2'b11;

    issue(0, OP_ADD, 256'd10, 256'd7, 256'd13, 4'd3, 256'd4, 1'b0, 1, 1'b1);
    issue(0, OP_SUB, 256'd3, 256'd5, 256'd13, 4'd7, 256'd11, 1'b0, 1, 1'b1);
    issue(0, OP_DBL, 256'd8, 256'd0, 256'd13, 4'd8, 256'd3, 1'b0, 1, 1'b1);
    issue(0, OP_NOP, 256'd9, 256'd4, 256'd13, 4'd10, 256'd9, 1'b0, 1, 1'b1);
    issue(0, OP_MUL, 256'd7, 256'd9, 256'd13, 4'd11, 256'd11, 1'b0, 8, 1'b1);
    busy_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      busy_ok = busy_ok & obusy[0];
    end
    check("mul_busy", 256'(busy_ok), 256'd1);
    issue(0, OP_SQR, 256'd12, 256'd0, 256'd13, 4'd12, 256'd1, 1'b0, 8, 1'b1);
    issue(0, 3'b111, 256'd5, 256'd6, 256'd13, 4'd9, 256'd0, 1'b1, 1, 1'b1);
    wait_idle(0);

    // Backpressure: hold the result for 5 cycles while another command waits.
    rdy_in[0] = 1'b0;
    issue(0, OP_ADD, 256'd1, 256'd2, 256'd13, 4'd5, 256'd3, 1'b0, 1, 1'b1);
    n = 0;
    while (!ov[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    fork
      issue(0, OP_ADD, 256'd4, 256'd5, 256'd13, 4'd6, 256'd9, 1'b0, 1, 1'b1);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_valid", 256'(ov[0]), 256'd1);
          check("bp_result", ores[0], 256'd3);
          check("bp_tag", 256'(otag[0]), 256'd5);
          check("bp_ready", 256'(ordy[0]), 256'd0);
        end
        rdy_in[0] = 1'b1;
      end
    join
    wait_idle(0);

    // Reset in the middle of a multiply aborts it.
    issue(0, OP_MUL, 256'd7, 256'd9, 256'd13, 4'd1, 256'd0, 1'b0, 8, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n_v[0] = 1'b0;
    #1;
    check("abort_valid", 256'(ov[0]), 256'd0);
    check("abort_busy", 256'(obusy[0]), 256'd0);
    check("abort_result", ores[0], 256'd0);
    check("abort_ready", 256'(ordy[0]), 256'd1);
    @(negedge clk);
    rst_n_v[0] = 1'b1;
    issue(0, OP_ADD, 256'd12, 256'd12, 256'd13, 4'd2, 256'd11, 1'b0, 1, 1'b1);
    wait_idle(0);

    issue(1, OP_ADD, P256 - 256'd1, 256'd1, P256, 4'd4, 256'd0, 1'b0, 1, 1'b1);
    issue(1, OP_ADD, P256 - 256'd2, 256'd5, P256, 4'd13, 256'd3, 1'b0, 1, 1'b1);
    issue(1, OP_MUL, P256 - 256'd1, P256 - 256'd1, P256, 4'd5, 256'd1, 1'b0, 256, 1'b1);
    wait_idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
